// File: rtl/pfd_lock_detect.sv
// pfd_lock_detect: oversampling PFD lock detector with hysteresis and reference-loss timeout
//   clk, rst          sampling clock (>=4x refclk), synchronous active-high reset
//   refclk, up, down  asynchronous reference clock and PFD pulses
//   lock              high in LOCKED or HOLD
//   ref_lost          high while no refclk edge has been seen for TIMEOUT cycles
//   win_valid         one-cycle strobe when up_pw/dn_pw update
//   up_pw, dn_pw      high-sample counts of the last closed window
//   state             0 UNLOCKED, 1 ACQUIRE, 2 LOCKED, 3 HOLD
module pfd_lock_detect #(
   parameter int PW_W       = 8,
   parameter int MAX_PW     = 2,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            refclk,
   input  logic            up,
   input  logic            down,
   output logic            lock,
   output logic            ref_lost,
   output logic            win_valid,
   output logic [PW_W-1:0] up_pw,
   output logic [PW_W-1:0] dn_pw,
   output logic [1:0]      state
);
   localparam logic [1:0] UNLOCKED = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2, HOLD = 2'd3;
   localparam int GC_W = $clog2(LOCK_CNT + 1);
   localparam int BC_W = $clog2(UNLOCK_CNT + 1);
   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [PW_W-1:0] MAX_L    = PW_W'(MAX_PW);
   localparam logic [GC_W-1:0] LOCK_L   = GC_W'(LOCK_CNT);
   localparam logic [BC_W-1:0] UNLOCK_L = BC_W'(UNLOCK_CNT);
   localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
   logic [1:0]      ref_s, up_s, dn_s;
   logic            ref_prev, armed, ref_edge, win_good;
   logic [PW_W-1:0] up_cnt, dn_cnt;
   logic [GC_W-1:0] good_cnt, gc_inc, gc_n;
   logic [BC_W-1:0] bad_cnt, bc_inc, bc_n;
   logic [TO_W-1:0] to_cnt;
   logic [1:0]      st_n;
   assign ref_edge = ref_s[1] & ~ref_prev;
   // the running counts become up_pw/dn_pw at the closing edge, so judge them directly
   assign win_good = (up_cnt <= MAX_L) && (dn_cnt <= MAX_L);
   assign gc_inc   = good_cnt + GC_W'(1);
   assign bc_inc   = bad_cnt + BC_W'(1);
   assign lock     = state[1];
   // good_cnt is zero in UNLOCKED, so UNLOCKED and ACQUIRE share one rule (likewise LOCKED/HOLD with bad_cnt)
   always_comb begin
      st_n = state;
      gc_n = '0;
      bc_n = '0;
      if (!state[1]) begin
         st_n = !win_good ? UNLOCKED : (gc_inc == LOCK_L) ? LOCKED : ACQUIRE;
         gc_n = (win_good && gc_inc != LOCK_L) ? gc_inc : '0;
      end else begin
         st_n = win_good ? LOCKED : (bc_inc == UNLOCK_L) ? UNLOCKED : HOLD;
         bc_n = (!win_good && bc_inc != UNLOCK_L) ? bc_inc : '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_s     <= '0;
         up_s      <= '0;
         dn_s      <= '0;
         ref_prev  <= 1'b0;
         armed     <= 1'b1;
         up_cnt    <= '0;
         dn_cnt    <= '0;
         good_cnt  <= '0;
         bad_cnt   <= '0;
         to_cnt    <= '0;
         ref_lost  <= 1'b0;
         win_valid <= 1'b0;
         up_pw     <= '0;
         dn_pw     <= '0;
         state     <= UNLOCKED;
      end else begin
         ref_s     <= {ref_s[0], refclk};
         up_s      <= {up_s[0], up};
         dn_s      <= {dn_s[0], down};
         ref_prev  <= ref_s[1];
         win_valid <= 1'b0;
         if (ref_edge) begin
            to_cnt   <= '0;
            ref_lost <= 1'b0;
            armed    <= 1'b0;
            up_cnt   <= PW_W'(up_s[1]);
            dn_cnt   <= PW_W'(dn_s[1]);
            if (!armed) begin
               up_pw     <= up_cnt;
               dn_pw     <= dn_cnt;
               win_valid <= 1'b1;
               state     <= st_n;
               good_cnt  <= gc_n;
               bad_cnt   <= bc_n;
            end
         end else if (to_cnt == TO_LAST) begin
            // counter parks at TIMEOUT so the loss event fires once per outage
            to_cnt   <= TO_MAX;
            ref_lost <= 1'b1;
            armed    <= 1'b1;
            state    <= UNLOCKED;
            up_cnt   <= '0;
            dn_cnt   <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
         end else begin
            to_cnt <= to_cnt + TO_W'(to_cnt != TO_MAX);
            up_cnt <= up_cnt + PW_W'(up_s[1] && !(&up_cnt));
            dn_cnt <= dn_cnt + PW_W'(dn_s[1] && !(&dn_cnt));
         end
      end
   end
endmodule

// File: tb/tb_pfd_lock_detect.sv
// tb_pfd_lock_detect: directed self-checking bench for pfd_lock_detect
module tb_pfd_lock_detect;
   logic       clk = 1'b0, rst = 1'b1, refclk = 1'b0, up = 1'b0, down = 1'b0;
   logic       lock, ref_lost, win_valid;
   logic [3:0] up_pw, dn_pw;
   logic [1:0] state;
   int         vecs = 0, errs = 0;
   int         p_wv, p_st, p_lk, p_rl0, p_rl, p_up, p_dn;
   pfd_lock_detect #(.PW_W(4), .MAX_PW(2), .LOCK_CNT(4), .UNLOCK_CNT(2), .TIMEOUT(40)) dut (
      .clk(clk), .rst(rst), .refclk(refclk), .up(up), .down(down), .lock(lock),
      .ref_lost(ref_lost), .win_valid(win_valid), .up_pw(up_pw), .dn_pw(dn_pw), .state(state)
   );
   always #1 clk = ~clk;
   task automatic chk(input string tag, input int obs, input int exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   // one 20-cycle refclk period; up/down high for the first nu/nd samples; outputs captured 3 cycles after the rise
   task automatic period(input int nu, input int nd);
      p_wv = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         p_wv += int'(win_valid);
         if (i == 0) p_rl0 = int'(ref_lost);
         if (i == 3) begin
            p_st = int'(state);
            p_lk = int'(lock);
            p_rl = int'(ref_lost);
            p_up = int'(up_pw);
            p_dn = int'(dn_pw);
         end
         refclk = (i < 10);
         up     = (i < nu);
         down   = (i < nd);
      end
   endtask
   task automatic step(input string tag, input int nu, input int nd, input int ewv, input int est, input int eup, input int edn);
      period(nu, nd);
      chk({tag, "_wv"}, p_wv, ewv);
      chk({tag, "_state"}, p_st, est);
      chk({tag, "_lock"}, p_lk, int'(est >= 2));
      chk({tag, "_up_pw"}, p_up, eup);
      chk({tag, "_dn_pw"}, p_dn, edn);
   endtask
   task automatic chk_zero(input string tag);
      chk(tag, int'({lock, ref_lost, win_valid, state, up_pw, dn_pw}), 0);
   endtask
   initial begin
      int n;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_zero("reset");
         refclk = 1'($urandom);
         up     = 1'($urandom);
         down   = 1'($urandom);
      end
      @(negedge clk);
      rst = 1'b0;
      refclk = 1'b0;
      up = 1'b0;
      down = 1'b0;
      step("acq1", 0, 0, 0, 0, 0, 0);
      step("acq2", 0, 0, 1, 1, 0, 0);
      step("acq3", 0, 0, 1, 1, 0, 0);
      step("acq4", 0, 0, 1, 1, 0, 0);
      step("acq5", 0, 0, 1, 2, 0, 0);
      step("hys1", 5, 0, 1, 2, 0, 0);
      step("hys2", 0, 0, 1, 3, 5, 0);
      step("hys3", 5, 0, 1, 2, 0, 0);
      step("hys4", 5, 0, 1, 3, 5, 0);
      step("hys5", 2, 2, 1, 0, 5, 0);
      step("sim1", 2, 2, 1, 1, 2, 2);
      step("sim2", 2, 2, 1, 1, 2, 2);
      step("sim3", 2, 2, 1, 1, 2, 2);
      step("sim4", 3, 3, 1, 2, 2, 2);
      step("sim5", 0, 0, 1, 3, 3, 3);
      step("sim6", 0, 0, 1, 2, 0, 0);
      n = 0;
      for (int i = 1; i <= 80 && n == 0; i++) begin
         @(negedge clk);
         if (ref_lost) n = i;
      end
      chk("lost_seen_in_window", int'(n >= 22 && n <= 26), 1);
      chk("lost_lock", int'(lock), 0);
      chk("lost_state", int'(state), 0);
      step("resume1", 0, 0, 0, 0, 0, 0);
      chk("resume1_lost_before", p_rl0, 1);
      chk("resume1_lost_after", p_rl, 0);
      step("resume2", 20, 0, 1, 1, 0, 0);
      step("sat", 0, 0, 1, 0, 15, 0);
      step("relock1", 1, 2, 1, 1, 0, 0);
      step("relock2", 1, 2, 1, 1, 1, 2);
      step("relock3", 1, 2, 1, 1, 1, 2);
      step("relock4", 1, 2, 1, 2, 1, 2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("mid_reset");
      rst = 1'b0;
      step("post1", 0, 0, 0, 0, 0, 0);
      step("post2", 0, 0, 1, 1, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
